encrypt_5b: RTL and testbench
=============================

Name: encrypt_5b

Overview:
- Upstream stage of the lab-5 decryptor.
- Reads a plaintext message from data memory starting at address 0.
- Prepends a preamble of underscore characters (8'h5f) and encrypts every byte by XORing bits [5:0] with a 6-bit LFSR state; bits [7:6] pass through unchanged.
- Writes the 64-byte ciphertext to data memory starting at address 64, where the decryptor reads it.

Parameters:
- PRE_LEN, 7: number of preamble bytes; legal range 7..12.
- CT_BASE, 64: first ciphertext write address.
- CT_LEN, 64: total ciphertext bytes written (preamble plus message).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- init_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin encryption; sampled only in IDLE.
- tap_sel  in  3  LFSR tap-pattern index 0..5 (6'h21, 2D, 30, 33, 36, 39); values 6..7 select 6'h21.
- seed  in  6  LFSR starting state; sampled with start.
- raddr  out  8  data memory read address.
- data_out  in  8  data memory read data; combinational (same-cycle) read.
- waddr  out  8  data memory write address.
- data_in  out  8  data memory write data.
- wr_en  out  1  data memory write enable.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.

Behaviour:
- Clock and reset: one clock (clk); reset init_n is synchronous and active-low.
- Reset (init_n=0 at a rising edge):
  - state goes to IDLE and k=0.
  - wr_en, busy, done, raddr, waddr and data_in are all 0.
  - Reset mid-RUN aborts immediately. No further writes occur; bytes already written stay in memory.
- LFSR step: next = {state[4:0], ^(state & taps)}. Taps and seed are latched into registers on the accepted start. A seed of 6'h00 is replaced by 6'h01 to avoid lock-up.
- IDLE:
  - All outputs are 0.
  - start=1 latches tap_sel (after the range clamp) and seed, then moves to LOAD.
- LOAD:
  - Lasts one cycle. The LFSR loads the latched seed.
  - wr_en=0 and busy=1.
  - Moves to RUN with k=0.
- RUN (k = 0..CT_LEN-1, one byte per cycle):
  - waddr = CT_BASE + k, modulo 256; wr_en=1.
  - For k < PRE_LEN: plaintext is 8'h5f and raddr=0.
  - Otherwise: raddr = k - PRE_LEN and plaintext is data_out.
  - data_in = {pt[7:6], pt[5:0] ^ lfsr_state}.
  - The LFSR advances every RUN cycle, so byte k uses the state after k steps from seed.
  - After k = CT_LEN-1, moves to DONE.
- DONE:
  - done=1, wr_en=0, busy=0; done holds until the next accepted start or reset.
  - start in DONE behaves as in IDLE: re-latch, go to LOAD, done drops on the next cycle.
- start while busy=1 is ignored and has no effect on the running job.
- Latency: start sampled at edge T:
  - LOAD during cycle T+1.
  - RUN during cycles T+2 .. T+CT_LEN+1.
  - done first high in cycle T+CT_LEN+2.
- Exactly CT_LEN writes per job. No write outside CT_BASE .. CT_BASE+CT_LEN-1.
- Width rules: k is a 7-bit counter. Address arithmetic is 8-bit unsigned and truncates on overflow.

Decomposition:
- Shared package enc_pkg:
  - state enum {IDLE, LOAD, RUN, DONE};
  - the LFSR_PTRN[6] constant array of tap patterns;
  - the PREAMBLE_CHAR = 8'h5f constant.
  The decryptor imports the same package.
- Sub-module: reuse the existing lfsr6b (clk, en, init, taps, start, state) as one instance; do not duplicate the LFSR logic.

Test Plan:
- Preamble check: tap_sel=0, seed=6'h01, start pulse → mem[64]=8'h5e (state 01), mem[65]=8'h5c (state 03), mem[66]=8'h58 (state 07). Bytes 64..70 are all 8'h5f ^ {2'b00, state_k}.
- Round trip: load "Mr. Watson, come here." at mem[0..], run every tap_sel 0..5 with seed 6'h2a, then run the decryptor → decryptor output equals the plaintext; the decryptor's detected pattern index equals tap_sel.
- Edge cases:
  - seed=6'h00 → behaves identically to seed=6'h01, with mem[64]=8'h5e for tap_sel=0.
  - tap_sel=7 → output identical to tap_sel=0.
- Timing and handshake:
  - done rises exactly CT_LEN+2 cycles after the start edge.
  - busy is high for exactly CT_LEN+1 cycles.
  - A second start pulse mid-RUN changes nothing; the ciphertext is bit-identical to a clean run.
- Reset mid-operation: init_n=0 at RUN k=20 → wr_en is 0 on the next cycle and mem[85..127] keep their prior contents. A subsequent start then completes normally with done=1.
- Parameter sweep: PRE_LEN=12 → mem[64..75] are encrypted 8'h5f, mem[76] is encrypted mem[0], and raddr never exceeds 51.

Source files
------------

// File: rtl/encrypt_5b_pkg.sv
// Shared definitions for the lab-5 encryptor and decryptor: FSM states,
// LFSR tap patterns and the preamble character.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [5:0] LFSR_PTRN [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
    localparam logic [7:0] PREAMBLE_CHAR = 8'h5f;

    // Out-of-range selectors fall back to the first pattern.
    function automatic logic [5:0] tap_lookup(input logic [2:0] sel);
        case (sel)
            3'd1:    return LFSR_PTRN[1];
            3'd2:    return LFSR_PTRN[2];
            3'd3:    return LFSR_PTRN[3];
            3'd4:    return LFSR_PTRN[4];
            3'd5:    return LFSR_PTRN[5];
            default: return LFSR_PTRN[0];
        endcase
    endfunction

endpackage

// File: rtl/encrypt_5b_if.sv
// Data-memory bus between the encryptor (master) and the memory (slave).
interface encrypt_5b_if;

    logic [7:0] raddr;
    logic [7:0] data_out;
    logic [7:0] waddr;
    logic [7:0] data_in;
    logic       wr_en;

    modport master (output raddr, waddr, data_in, wr_en, input data_out);
    modport slave  (input raddr, waddr, data_in, wr_en, output data_out);

endinterface

// File: rtl/encrypt_5b_lfsr6b.sv
// 6-bit Fibonacci LFSR: init loads the start value, en advances one step.
module lfsr6b (
    input  logic       clk,
    input  logic       en,
    input  logic       init,
    input  logic [5:0] taps,
    input  logic [5:0] start,
    output logic [5:0] state
);

    always_ff @(posedge clk) begin
        if (init) begin
            state <= start;
        end else if (en) begin
            state <= {state[4:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/encrypt_5b.sv
// Lab-5 encryptor: prepends a preamble to the plaintext at address 0 and writes
// the LFSR-scrambled ciphertext starting at CT_BASE.
module encrypt_5b
    import enc_pkg::*;
#(
    parameter int unsigned PRE_LEN = 7,
    parameter int unsigned CT_BASE = 64,
    parameter int unsigned CT_LEN  = 64
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              start,
    input  logic [2:0]        tap_sel,
    input  logic [5:0]        seed,
    encrypt_5b_if.master      mem,
    output logic              busy,
    output logic              done
);

    state_t     state, state_nx;
    logic [6:0] k;
    logic [5:0] taps_r;
    logic [5:0] seed_r;
    logic [5:0] lfsr_state;
    logic [7:0] pt;
    logic       accept;

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state  <= IDLE;
            k      <= '0;
            taps_r <= '0;
            seed_r <= '0;
        end else begin
            state <= state_nx;
            k     <= (state == RUN) ? k + 7'd1 : '0;
            if (accept) begin
                taps_r <= tap_lookup(tap_sel);
                // An all-zero seed would lock the LFSR.
                seed_r <= (seed == 6'h00) ? 6'h01 : seed;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        pt           = '0;
        mem.raddr    = '0;
        mem.waddr    = '0;
        mem.data_in  = '0;
        mem.wr_en    = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    accept   = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                mem.wr_en = 1'b1;
                mem.waddr = 8'(CT_BASE) + 8'(k);
                if (k < 7'(PRE_LEN)) begin
                    pt = PREAMBLE_CHAR;
                end else begin
                    mem.raddr = 8'(k) - 8'(PRE_LEN);
                    pt        = mem.data_out;
                end
                mem.data_in = {pt[7:6], pt[5:0] ^ lfsr_state};
                if (k == 7'(CT_LEN - 1)) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    lfsr6b u_lfsr (
        .clk   (clk),
        .en    (state == RUN),
        .init  (state == LOAD),
        .taps  (taps_r),
        .start (seed_r),
        .state (lfsr_state)
    );

endmodule

// File: tb/tb_encrypt_5b.sv
// Self-checking bench for encrypt_5b: directed vector table plus hand-written
// timing, restart, reset-abort and PRE_LEN=12 sequences.
module tb_encrypt_5b;

    logic       clk = 1'b0;
    logic       init_n;
    logic       start0, start1;
    logic [2:0] tap_sel;
    logic [5:0] seed;
    logic       busy0, done0, busy1, done1;

    always #5 clk = ~clk;

    encrypt_5b_if m0 ();
    encrypt_5b_if m1 ();

    encrypt_5b #(.PRE_LEN(7), .CT_BASE(64), .CT_LEN(64)) dut0 (
        .clk(clk), .init_n(init_n), .start(start0), .tap_sel(tap_sel), .seed(seed),
        .mem(m0), .busy(busy0), .done(done0)
    );

    encrypt_5b #(.PRE_LEN(12), .CT_BASE(64), .CT_LEN(64)) dut1 (
        .clk(clk), .init_n(init_n), .start(start1), .tap_sel(tap_sel), .seed(seed),
        .mem(m1), .busy(busy1), .done(done1)
    );

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       pl_we;
    logic [7:0] pl_a, pl_d;
    int         wr_cnt0 = 0;
    int         bad_wr0 = 0;
    int         raddr_max1 = 0;

    assign m0.data_out = mem0[m0.raddr];
    assign m1.data_out = mem1[m1.raddr];

    always @(posedge clk) begin
        if (pl_we) begin
            mem0[pl_a] <= pl_d;
            mem1[pl_a] <= pl_d;
        end else begin
            if (m0.wr_en) begin
                mem0[m0.waddr] <= m0.data_in;
                wr_cnt0 <= wr_cnt0 + 1;
                if (m0.waddr < 8'd64 || m0.waddr > 8'd127) bad_wr0 <= bad_wr0 + 1;
            end
            if (m1.wr_en) mem1[m1.waddr] <= m1.data_in;
        end
        if (int'(m1.raddr) > raddr_max1) raddr_max1 <= int'(m1.raddr);
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pt [64];
    logic [7:0] snap [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_we = 1'b1;
        tick();
        pl_we = 1'b0;
    endtask

    function automatic logic [5:0] mtap(input int s);
        case (s)
            1:       return 6'h2D;
            2:       return 6'h30;
            3:       return 6'h33;
            4:       return 6'h36;
            5:       return 6'h39;
            default: return 6'h21;
        endcase
    endfunction

    function automatic logic [5:0] mstate(input int ts, input logic [5:0] sd, input int k);
        logic [5:0] st;
        st = (sd == 6'h00) ? 6'h01 : sd;
        for (int i = 0; i < k; i++) st = {st[4:0], ^(st & mtap(ts))};
        return st;
    endfunction

    function automatic logic [7:0] exp_ct(input int pre, input int ts, input logic [5:0] sd, input int k);
        logic [7:0] p;
        p = (k < pre) ? 8'h5f : pt[k - pre];
        return {p[7:6], p[5:0] ^ mstate(ts, sd, k)};
    endfunction

    function automatic logic [7:0] rd_mem(input bit which, input int a);
        return which ? mem1[a] : mem0[a];
    endfunction

    task automatic run_job(input bit which, input logic [2:0] ts, input logic [5:0] sd,
                           input int glitch, output int cyc, output int busy_cnt);
        tap_sel = ts;
        seed    = sd;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start0   = 1'b0;
        start1   = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!(which ? done1 : done0) && cyc < 200) begin
            if (which ? busy1 : busy0) busy_cnt++;
            if (cyc == glitch) begin
                start0  = 1'b1;
                tap_sel = 3'd5;
                seed    = 6'h3f;
            end
            tick();
            start0 = 1'b0;
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL job_timeout actual=%0d required=66", cyc);
        end
    endtask

    task automatic check_full(input string name, input bit which, input int pre,
                              input int ts, input logic [5:0] sd);
        int nbad = 0;
        for (int k = 0; k < 64; k++)
            if (rd_mem(which, 64 + k) !== exp_ct(pre, ts, sd, k)) nbad++;
        check(name, nbad, 0);
    endtask

    typedef struct {
        logic [2:0] ts;
        logic [5:0] sd;
        logic [7:0] b [4];
    } vec_t;

    vec_t vt [7];

    initial begin
        string msg;
        int    cyc, bcnt, w0, nbad;

        vt[0] = '{ts: 3'd0, sd: 6'h01, b: '{8'h5e, 8'h5c, 8'h58, 8'h50}};
        vt[1] = '{ts: 3'd0, sd: 6'h00, b: '{8'h5e, 8'h5c, 8'h58, 8'h50}};
        vt[2] = '{ts: 3'd7, sd: 6'h01, b: '{8'h5e, 8'h5c, 8'h58, 8'h50}};
        vt[3] = '{ts: 3'd1, sd: 6'h01, b: '{8'h5e, 8'h5c, 8'h58, 8'h51}};
        vt[4] = '{ts: 3'd2, sd: 6'h01, b: '{8'h5e, 8'h5d, 8'h5b, 8'h57}};
        vt[5] = '{ts: 3'd3, sd: 6'h01, b: '{8'h5e, 8'h5c, 8'h59, 8'h52}};
        vt[6] = '{ts: 3'd0, sd: 6'h2a, b: '{8'h75, 8'h4a, 8'h74, 8'h49}};

        init_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        tap_sel = '0; seed = '0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
        repeat (3) tick();
        check("reset_outs", {m0.raddr, m0.waddr, m0.data_in, m0.wr_en, busy0, done0}, 0);
        init_n = 1'b1;
        tick();
        check("idle_outs", {m0.raddr, m0.waddr, m0.data_in, m0.wr_en, busy0, done0}, 0);

        msg = "Mr. Watson, come here.";
        for (int i = 0; i < 64; i++) begin
            pt[i] = (i < msg.len()) ? msg[i] : 8'(8'h80 + i * 3);
            poke(8'(i), pt[i]);
        end
        for (int i = 64; i < 128; i++) poke(8'(i), 8'hAA);

        foreach (vt[v]) begin
            w0 = wr_cnt0;
            run_job(1'b0, vt[v].ts, vt[v].sd, 0, cyc, bcnt);
            check($sformatf("done_latency_v%0d", v), cyc, 66);
            check($sformatf("busy_len_v%0d", v), bcnt, 65);
            check($sformatf("write_count_v%0d", v), wr_cnt0 - w0, 64);
            for (int j = 0; j < 4; j++)
                check($sformatf("ct_v%0d_b%0d", v, j), mem0[64 + j], vt[v].b[j]);
            check_full($sformatf("full_v%0d", v), 1'b0, 7, int'(vt[v].ts), vt[v].sd);
        end

        for (int ts = 0; ts < 6; ts++) begin
            run_job(1'b0, 3'(ts), 6'h2a, 0, cyc, bcnt);
            nbad = 0;
            for (int k = 0; k < 64; k++)
                if ((mem0[64 + k] ^ {2'b00, mstate(ts, 6'h2a, k)}) !== ((k < 7) ? 8'h5f : pt[k - 7]))
                    nbad++;
            check($sformatf("roundtrip_tap%0d", ts), nbad, 0);
        end

        run_job(1'b0, 3'd4, 6'h13, 0, cyc, bcnt);
        for (int i = 0; i < 64; i++) snap[i] = mem0[64 + i];
        for (int i = 64; i < 128; i++) poke(8'(i), 8'hAA);
        run_job(1'b0, 3'd4, 6'h13, 30, cyc, bcnt);
        check("restart_latency", cyc, 66);
        nbad = 0;
        for (int i = 0; i < 64; i++) if (mem0[64 + i] !== snap[i]) nbad++;
        check("restart_ignored", nbad, 0);

        for (int i = 64; i < 128; i++) poke(8'(i), 8'hC3);
        tap_sel = 3'd1;
        seed    = 6'h05;
        start0  = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (21) tick();
        check("abort_k20_waddr", m0.waddr, 84);
        init_n = 1'b0;
        tick();
        check("abort_outs", {m0.wr_en, busy0, done0}, 0);
        init_n = 1'b1;
        tick();
        check("abort_last_byte", mem0[84], exp_ct(7, 1, 6'h05, 20));
        nbad = 0;
        for (int i = 85; i < 128; i++) if (mem0[i] !== 8'hC3) nbad++;
        check("abort_untouched", nbad, 0);
        run_job(1'b0, 3'd1, 6'h05, 0, cyc, bcnt);
        check("after_abort_latency", cyc, 66);
        check("after_abort_done", done0, 1);
        check_full("after_abort_full", 1'b0, 7, 1, 6'h05);

        run_job(1'b1, 3'd0, 6'h01, 0, cyc, bcnt);
        check("pre12_latency", cyc, 66);
        check("pre12_mem75", mem1[75], 8'h5f ^ {2'b00, mstate(0, 6'h01, 11)});
        check("pre12_mem76", mem1[76], exp_ct(12, 0, 6'h01, 12));
        check_full("pre12_full", 1'b1, 12, 0, 6'h01);
        check("pre12_raddr_max", raddr_max1, 51);

        check("out_of_range_writes", bad_wr0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
